ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with inhibit, request-to-send, ACK check and timeout
module ps2_host_tx #(
   parameter int CLK_INHIBIT_CYCLES = 6000,
   parameter int TIMEOUT_CYCLES     = 1000000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       send_cmd,
   input  logic [7:0] cmd_byte,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       tx_error,
   output logic       timeout
);
   localparam int CW = $clog2((CLK_INHIBIT_CYCLES > TIMEOUT_CYCLES ? CLK_INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(CLK_INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;
   state_t        state_q, state_d;
   logic [1:0]    clk_sync_q, dat_sync_q;
   logic          clk_prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [9:0]    frame_q, frame_d;
   logic          dat_oe_q, dat_oe_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          to_q, to_d;
   logic          clk_s, dat_s, fall, expire;
   assign clk_s      = clk_sync_q[1];
   assign dat_s      = dat_sync_q[1];
   assign fall       = clk_prev_q & ~clk_s;
   assign ps2_clk_oe = (state_q == INHIBIT) || (state_q == RTS);
   assign ps2_dat_oe = (state_q == RTS) || (state_q == SEND && dat_oe_q);
   assign busy       = state_q != IDLE;
   assign done       = done_q;
   assign tx_error   = err_q;
   assign timeout    = to_q;
   // Resynchronise the asynchronous PS/2 pins; idle level of the bus is high
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
         dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
         clk_prev_q <= clk_s;
      end
   end
   // Transaction state, shared inhibit/timeout counter, frame shifter and result flags
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         frame_q  <= '0;
         dat_oe_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         frame_q  <= frame_d;
         dat_oe_q <= dat_oe_d;
         done_q   <= done_d;
         err_q    <= err_d;
         to_q     <= to_d;
      end
   end
   // Next-state logic; a device clock edge always wins over an expiring timeout
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      bit_d    = bit_q;
      frame_d  = frame_q;
      dat_oe_d = dat_oe_q;
      done_d   = 1'b0;
      err_d    = err_q;
      to_d     = to_q;
      expire   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (send_cmd) begin
               frame_d = {1'b1, ~^cmd_byte, cmd_byte};
               err_d   = 1'b0;
               to_d    = 1'b0;
               state_d = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               cnt_d   = '0;
               state_d = RTS;
            end
         end
         RTS: begin
            cnt_d    = '0;
            bit_d    = '0;
            dat_oe_d = 1'b1;
            state_d  = SEND;
         end
         SEND: begin
            if (fall) begin
               cnt_d = '0;
               if (bit_q == 4'd10) state_d = ACK;
               else begin
                  dat_oe_d = ~frame_q[bit_q];
                  bit_d    = bit_q + 1'b1;
               end
            end else expire = cnt_q == TO_LAST;
         end
         ACK: begin
            if (fall) begin
               cnt_d   = '0;
               err_d   = dat_s;
               state_d = WAIT_IDLE;
            end else expire = cnt_q == TO_LAST;
         end
         WAIT_IDLE: begin
            if (clk_s && dat_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (fall) cnt_d = '0;
            else expire = cnt_q == TO_LAST;
         end
         default: state_d = IDLE;
      endcase
      if (expire) begin
         cnt_d    = '0;
         dat_oe_d = 1'b0;
         done_d   = 1'b1;
         err_d    = 1'b1;
         to_d     = 1'b1;
         state_d  = IDLE;
      end
   end
endmodule
